// File: rtl/icache_direct_if.sv
// icache_direct_if
//   Groups the two buses of the direct-mapped instruction cache:
//     fetch port  : imemREN, imemaddr, iflush (to cache); ihit, imemload (from cache)
//     arbiter port: iREN, iaddr (from cache); iwait, iload (to cache)
//   Modports:
//     slave  - cache side (answers the fetch port, drives the arbiter port)
//     master - environment side (datapath fetch stage plus memory arbiter)
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_direct.sv
// icache_direct
//   Direct-mapped, read-only instruction cache. A hit is answered in the same
//   cycle as the request; a miss runs a single-word refill against the memory
//   arbiter. No dirty state is kept, so there is no writeback path.
// Ports:
//   CLK  - clock, all state updates on posedge
//   RST  - synchronous reset, active high
//   bus  - icache_direct_if.slave (fetch port + arbiter port)
//   hit_count / miss_count - saturating statistics counters, present only
//                            when the ICACHE_STATS_EN macro is defined
// Optional build macro: ICACHE_STATS_EN
module icache_direct #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic          CLK,
    input  logic          RST,
    icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state, next_state;

    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [31:0]      data_arr [SETS];
    logic [SETS-1:0]  valid;

    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             start_miss;
    logic             fill_en;

    // The byte offset bits carry no information for word fetches.
    logic unused_byte_offset;
    assign unused_byte_offset = ^bus.imemaddr[1:0];

    assign req_idx = bus.imemaddr[IDX_W+1:2];
    assign req_tag = bus.imemaddr[31:IDX_W+2];

    // Lookup only counts as a hit while idle; a flush in the same cycle
    // suppresses it because the frame is about to become invalid.
    assign hit = bus.imemREN && (state == IDLE) && !bus.iflush &&
                 valid[req_idx] && (tag_arr[req_idx] == req_tag);

    assign start_miss = (state == IDLE) && bus.imemREN && !hit && !bus.iflush;

    // The refill lands only if the datapath still wants the instruction and
    // no flush is racing it; otherwise the fetch is abandoned.
    assign fill_en = (state == FETCH) && bus.imemREN && !bus.iwait && !bus.iflush;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: abort, flush and completion all return to IDLE so the
    // current address is looked up afresh.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start_miss) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (bus.iflush || !bus.imemREN || !bus.iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs: iREN and iaddr decode only registered state, which keeps the
    // arbiter request free of any combinational path from the fetch port.
    always_comb begin
        bus.ihit     = hit;
        bus.imemload = data_arr[req_idx];
        bus.iREN     = (state == FETCH);
        bus.iaddr    = {miss_tag, miss_idx, 2'b00};
    end

    // Miss address is captured when the refill starts and held so pipeline
    // address changes during FETCH cannot redirect the refill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            miss_tag <= '0;
            miss_idx <= '0;
        end else if (start_miss) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
        end
    end

    // Valid bits: flush clears everything and takes priority over a fill.
    always_ff @(posedge CLK) begin
        if (RST || bus.iflush) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[miss_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are never cleared; valid bits guard them.
    always_ff @(posedge CLK) begin
        if (fill_en && !RST) begin
            tag_arr[miss_idx]  <= miss_tag;
            data_arr[miss_idx] <= bus.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    // Statistics counters saturate instead of wrapping and survive flushes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
